fetch_sequencer: RTL and testbench

Instruction-fetch controller for the pipelined core. It owns the fetch PC, issues one request at a time to instruction memory over a variable-latency req/rvalid interface, and presents fetched instructions to decode through a registered output stage backed by a one-entry skid buffer. It also applies execute-stage redirects (branch/jal/jalr), squashing both buffered instructions and the response still in flight.

---
 rtl/fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: one outstanding imem request, registered output stage
// with a one-entry skid buffer, execute-stage redirect with in-flight squash.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      kill_cnt_o
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_KILL  = 2'd3;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(3'd4);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] pc_r;
  logic             valid_r;
  logic [WIDTH-1:0] instr_r;
  logic [WIDTH-1:0] pc_out_r;
  logic [WIDTH-1:0] skid_instr_r;
  logic [WIDTH-1:0] skid_pc_r;

  logic consume_s;
  logic resp_s;
  logic load_out_s;
  logic load_skid_s;
  logic unload_skid_s;

  assign consume_s     = valid_r & ~stall_i;
  assign resp_s        = (state_r == S_WAIT) & imem_rvalid_i & ~redirect_i;
  assign load_out_s    = resp_s & (~valid_r | consume_s);
  assign load_skid_s   = resp_s & valid_r & ~consume_s;
  assign unload_skid_s = (state_r == S_HOLD) & consume_s & ~redirect_i;

  // Next-state selection; redirect overrides the normal flow.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_i) begin
      // A response still owed by memory must be absorbed in KILL before refetching.
      if (((state_r == S_WAIT) || (state_r == S_KILL)) && !imem_rvalid_i) begin
        state_nxt_s = S_KILL;
      end else begin
        state_nxt_s = S_FETCH;
      end
    end else begin
      case (state_r)
        S_FETCH: state_nxt_s = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_nxt_s = load_skid_s ? S_HOLD : S_FETCH;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_HOLD: begin
          if (consume_s) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_HOLD;
          end
        end
        S_KILL: begin
          if (imem_rvalid_i) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_KILL;
          end
        end
        default: state_nxt_s = S_FETCH;
      endcase
    end
  end

  // FSM state and fetch PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      if (redirect_i) begin
        pc_r <= redirect_pc_i;
      end else if (resp_s) begin
        pc_r <= pc_r + PC_STEP;
      end
    end
  end

  // Output register: load from memory, refill from skid, or drain on consume.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      valid_r  <= 1'b0;
      instr_r  <= '0;
      pc_out_r <= '0;
    end else if (load_out_s) begin
      valid_r  <= 1'b1;
      instr_r  <= imem_rdata_i;
      pc_out_r <= pc_r;
    end else if (unload_skid_s) begin
      valid_r  <= 1'b1;
      instr_r  <= skid_instr_r;
      pc_out_r <= skid_pc_r;
    end else if (consume_s) begin
      valid_r  <= 1'b0;
    end
  end

  // Skid register captures a response that arrives while decode is stalled.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      skid_instr_r <= '0;
      skid_pc_r    <= '0;
    end else if (load_skid_s) begin
      skid_instr_r <= imem_rdata_i;
      skid_pc_r    <= pc_r;
    end
  end

  assign imem_req_o  = (state_r == S_FETCH) & ~redirect_i & ~rst;
  assign imem_addr_o = pc_r;
  assign valid_o     = valid_r;
  assign instr_o     = instr_r;
  assign pc_o        = pc_out_r;
  assign pc_plus4_o  = pc_out_r + PC_STEP;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] kill_cnt_r;
  logic        drop_s;

  assign drop_s = imem_rvalid_i &
                  ((state_r == S_KILL) | ((state_r == S_WAIT) & redirect_i));

  // Delivered and discarded instruction counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r <= 32'h0;
      kill_cnt_r  <= 32'h0;
    end else begin
      if (consume_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (drop_s) begin
        kill_cnt_r <= kill_cnt_r + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_r;
  assign kill_cnt_o  = kill_cnt_r;
`else
  assign fetch_cnt_o = 32'h0;
  assign kill_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: behavioral variable-latency imem plus an
// expected-PC queue checked whenever decode consumes an instruction.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] fcnt;
  logic [31:0] kcnt;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .valid_o      (valid),
    .instr_o      (instr),
    .pc_o         (pc),
    .pc_plus4_o   (pc4),
    .fetch_cnt_o  (fcnt),
    .kill_cnt_o   (kcnt)
  );

  int total = 0;
  int bad   = 0;

  int          lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_rem = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] exp_q[$];

  logic        o_req;
  logic [31:0] o_addr;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_fcnt;
  logic [31:0] o_kcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs and memory response, sample, then advance.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    rvalid      = 1'b0;
    rdata       = 32'h0;
    if (rst) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_rem--;
      if (mem_rem == 0) begin
        rvalid   = 1'b1;
        rdata    = mem_addr ^ KEY;
        mem_busy = 1'b0;
      end
    end
    #1;
    o_req = req; o_addr = addr; o_valid = valid; o_instr = instr;
    o_pc = pc; o_pc4 = pc4; o_fcnt = fcnt; o_kcnt = kcnt;
    if (req && !rst) begin
      mem_busy = 1'b1;
      mem_rem  = lat;
      mem_addr = addr;
    end
    if (valid && !st && !rst) begin
      if (exp_q.size() == 0) begin
        check("extra_delivery_pc", pc, 32'hFFFF_FFFF ^ pc);
      end else begin
        e = exp_q.pop_front();
        check("deliver_pc", pc, e);
        check("deliver_instr", instr, e ^ KEY);
        check("deliver_pc_plus4", pc4, e + 32'd4);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic run_until_req(input logic [31:0] a, input bit st, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      step(st, 1'b0, 32'h0);
      n++;
      if (o_req && o_addr == a) return;
    end
    check("req_timeout", 32'(n), 32'(budget + 1));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0, 1'b0, 32'h0);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);

    // Reset values
    do_reset(2);
    check("rst_req", {31'b0, o_req}, 32'd0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_pc4", o_pc4, 32'd4);
    check("rst_fcnt", o_fcnt, 32'd0);
    check("rst_kcnt", o_kcnt, 32'd0);

    // Straight-line fetch, L=1: six deliveries, last one at cycle 12
    lat = 1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    check("straight_cycles", 32'(n), 32'd13);

    // Stall/skid
    do_reset(1);
    lat = 1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("stall_first_valid", {31'b0, o_valid}, 32'd1);
    check("stall_req4", {o_addr[31:1], o_req}, 32'h5);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (o_req) n++;
    end
    check("stall_no_reqs", 32'(n), 32'd0);
    check("stall_pc_held", o_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("release_no_req", {31'b0, o_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("release_req8", {o_addr[31:1], o_req}, 32'h9);
    drain(20);

    // Redirect in WAIT, L=3
    do_reset(1);
    lat = 3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h100);
    run_until_req(32'h8, 1'b0, 30, n);
    step(1'b0, 1'b1, 32'h100);
    check("redir_wait_noreq", {31'b0, o_req}, 32'd0);
    run_until_req(32'h100, 1'b0, 10, n);
    check("kill_latency", 32'(n), 32'd3);
    check("kill_cnt", o_kcnt, PERF ? 32'd1 : 32'd0);
    check("fetch_cnt_c", o_fcnt, PERF ? 32'd2 : 32'd0);
    drain(20);

    // Redirect coincident with rvalid, then redirect with skid full
    do_reset(1);
    lat = 2;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    check("coinc_noreq", {31'b0, o_req}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    check("coinc_req_target", {o_addr[31:1], o_req}, 32'h201);
    check("coinc_valid", {31'b0, o_valid}, 32'd0);
    check("coinc_kill_cnt", o_kcnt, PERF ? 32'd1 : 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    check("skid_valid", {31'b0, o_valid}, 32'd1);
    check("skid_pc", o_pc, 32'h200);
    check("skid_hold_noreq", {31'b0, o_req}, 32'd0);
    exp_q.push_back(32'h300);
    step(1'b1, 1'b1, 32'h300);
    check("skid_redir_noreq", {31'b0, o_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("skid_cleared", {31'b0, o_valid}, 32'd0);
    check("skid_redir_req", {o_addr[31:1], o_req}, 32'h301);
    drain(20);

    // Wrap, then reset while in WAIT
    do_reset(1);
    lat = 2;
    exp_q.push_back(32'hFFFF_FFFC);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_redir_noreq", {31'b0, o_req}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_req", {o_addr[31:1], o_req}, 32'hFFFF_FFFD);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_next_addr", {o_addr[31:1], o_req}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_fetch_cnt", o_fcnt, PERF ? 32'd1 : 32'd0);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    check("midrst_req", {o_addr[31:1], o_req}, 32'h1);
    check("midrst_valid", {31'b0, o_valid}, 32'd0);
    check("midrst_fcnt", o_fcnt, 32'd0);
    check("midrst_kcnt", o_kcnt, 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
